// File: rtl/spi_buffer_arbiter_if.sv
// Bundle of the arbiter's data-path, RAM-port and status signals.
// slave = the arbiter itself, master = the SPI receiver/consumer/RAM side.
interface spi_buffer_arbiter_if #(
  parameter int DEPTH_LOG2 = 15,
  parameter int DATA_W     = 16
);
  logic                  clear;
  logic                  wr_pulse;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_req;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DEPTH_LOG2:0]   level;
  logic                  empty;
  logic                  full;
  logic                  overflow;

  modport slave (
    input  clear, wr_pulse, wr_data, rd_req, ram_rdata,
    output rd_valid, rd_data, ram_addr, ram_wdata, ram_we, ram_re,
           level, empty, full, overflow
  );

  modport master (
    output clear, wr_pulse, wr_data, rd_req, ram_rdata,
    input  rd_valid, rd_data, ram_addr, ram_wdata, ram_we, ram_re,
           level, empty, full, overflow
  );
endinterface

// File: rtl/spi_buffer_arbiter.sv
// Circular FIFO over a single-port RAM. Writes from the SPI receiver are
// never stalled: if the port is busy with a read, the word parks in a
// one-entry pending register and commits on the next free cycle. Reads go
// through a 3-state FSM (issue, RAM latency, deliver).
module spi_buffer_arbiter #(
  parameter int DEPTH_LOG2 = 15,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_buffer_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD, DATA} state_t;

  localparam logic [DEPTH_LOG2:0]   DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE     = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = 1;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, pend_addr;
  logic [DATA_W-1:0]     pend_data;
  logic                  pend_vld;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;

  logic                  full_w, accept, drop;
  logic                  commit_pend, commit_new, stash_new, issue;
  logic                  we, re;
  logic [DEPTH_LOG2-1:0] addr;
  logic [DATA_W-1:0]     wdata;

  // Acceptance is decided purely on occupancy; clear wins over a same-cycle write.
  assign full_w = (level == DEPTH_WORDS);
  assign accept = bus.wr_pulse & ~full_w & ~bus.clear;
  assign drop   = bus.wr_pulse &  full_w & ~bus.clear;

  // Port arbitration (pending write > new write > read issue) and FSM next state.
  // Port outputs are forced idle while reset is asserted, without waiting for a clock.
  always_comb begin
    state_nxt   = state;
    we          = 1'b0;
    re          = 1'b0;
    addr        = '0;
    wdata       = '0;
    commit_pend = 1'b0;
    commit_new  = 1'b0;
    stash_new   = 1'b0;
    issue       = 1'b0;
    if (reset && !bus.clear) begin
      case (state)
        IDLE, DATA: begin
          if (pend_vld) begin
            we          = 1'b1;
            addr        = pend_addr;
            wdata       = pend_data;
            commit_pend = 1'b1;
            stash_new   = accept;
          end else if (accept) begin
            we         = 1'b1;
            addr       = wr_ptr;
            wdata      = bus.wr_data;
            commit_new = 1'b1;
          end else if (state == IDLE && !bus.wr_pulse && bus.rd_req && level != '0) begin
            re    = 1'b1;
            addr  = rd_ptr;
            issue = 1'b1;
          end
          state_nxt = (state == DATA) ? IDLE : (issue ? RD : IDLE);
        end
        RD: begin
          // Port is reserved for the returning read data; park any new word.
          stash_new = accept;
          state_nxt = DATA;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register; clear aborts any in-flight read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         state <= IDLE;
    else if (bus.clear) state <= IDLE;
    else                state <= state_nxt;
  end

  // Pointers, occupancy, pending slot, overflow flag and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else if (bus.clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      pend_vld <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (commit_pend || commit_new) wr_ptr <= wr_ptr + PTR_ONE;
      if (issue)                     rd_ptr <= rd_ptr + PTR_ONE;
      // Issue requires no wr_pulse, so accept and issue are mutually exclusive.
      if (accept)     level <= level + LVL_ONE;
      else if (issue) level <= level - LVL_ONE;
      if (drop) overflow <= 1'b1;
      if (stash_new) begin
        pend_vld  <= 1'b1;
        // If the old pending word commits now, the new one lands one slot later.
        pend_addr <= commit_pend ? wr_ptr + PTR_ONE : wr_ptr;
        pend_data <= bus.wr_data;
      end else if (commit_pend) begin
        pend_vld <= 1'b0;
      end
      // RAM data is valid during RD; present it for exactly the DATA cycle.
      rd_valid <= (state == RD);
      if (state == RD) rd_data <= bus.ram_rdata;
    end
  end

  assign bus.ram_we    = we;
  assign bus.ram_re    = re;
  assign bus.ram_addr  = addr;
  assign bus.ram_wdata = wdata;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.level     = level;
  assign bus.empty     = (level == '0);
  assign bus.full      = full_w;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_spi_buffer_arbiter.sv
// Directed bench for spi_buffer_arbiter, run at a reduced depth (64 words)
// so full/wrap cases stay short. A behavioural RAM with 1-cycle read latency
// sits on the port; a queue holds the expected read order.
module tb_spi_buffer_arbiter;
  localparam int D = 6;
  localparam int N = 1 << D;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   overlap = 0;
  logic [15:0] q[$];
  logic [15:0] mem [0:N-1];

  always #5 clk = ~clk;

  spi_buffer_arbiter_if #(.DEPTH_LOG2(D), .DATA_W(16)) bus ();

  spi_buffer_arbiter #(.DEPTH_LOG2(D), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-port RAM model: write on we, registered read data one cycle after re.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Port must never be driven for write and read in the same cycle.
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1 && bus.ram_re === 1'b1) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [15:0] d);
    bus.wr_pulse = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_pulse = 1'b0;
    q.push_back(d);
  endtask

  task automatic read_q();
    logic        got;
    logic [15:0] exp;
    exp = q.pop_front();
    got = 1'b0;
    bus.rd_req = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (bus.rd_valid === 1'b1) got = 1'b1;
    end
    bus.rd_req = 1'b0;
    chk("rd_valid_seen", {31'd0, got}, 32'd1);
    chk("rd_data_order", {16'd0, bus.rd_data}, {16'd0, exp});
  endtask

  initial begin
    reset        = 1'b0;
    bus.clear    = 1'b0;
    bus.wr_pulse = 1'b1;
    bus.wr_data  = 16'hFFFF;
    bus.rd_req   = 1'b1;
    #12;
    // reset state, with live inputs that must not leak to the RAM port
    chk("rst_level",    {25'd0, bus.level}, 32'd0);
    chk("rst_empty",    {31'd0, bus.empty}, 32'd1);
    chk("rst_full",     {31'd0, bus.full}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rd_data",  {16'd0, bus.rd_data}, 32'd0);
    chk("rst_ram_we",   {31'd0, bus.ram_we}, 32'd0);
    chk("rst_ram_re",   {31'd0, bus.ram_re}, 32'd0);
    chk("rst_ram_addr", {26'd0, bus.ram_addr}, 32'd0);
    bus.wr_pulse = 1'b0;
    bus.rd_req   = 1'b0;
    #1 reset = 1'b1;
    tick();

    // two writes, then back-to-back reads with rd_req held
    bus.wr_pulse = 1'b1; bus.wr_data = 16'hA5A5; #1;
    chk("w0_we",    {31'd0, bus.ram_we}, 32'd1);
    chk("w0_addr",  {26'd0, bus.ram_addr}, 32'd0);
    chk("w0_wdata", {16'd0, bus.ram_wdata}, 32'h0000A5A5);
    tick();
    bus.wr_data = 16'h1234; #1;
    chk("w1_addr",  {26'd0, bus.ram_addr}, 32'd1);
    tick();
    bus.wr_pulse = 1'b0;
    bus.rd_req = 1'b1; #1;
    chk("lvl_2",      {25'd0, bus.level}, 32'd2);
    chk("issue0_re",  {31'd0, bus.ram_re}, 32'd1);
    chk("issue0_we",  {31'd0, bus.ram_we}, 32'd0);
    chk("issue0_adr", {26'd0, bus.ram_addr}, 32'd0);
    tick();
    chk("rd_lvl_1",   {25'd0, bus.level}, 32'd1);
    chk("rd_novalid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rd_port_re", {31'd0, bus.ram_re}, 32'd0);
    tick();
    chk("data0_vld",  {31'd0, bus.rd_valid}, 32'd1);
    chk("data0_val",  {16'd0, bus.rd_data}, 32'h0000A5A5);
    tick();
    chk("idle_vld0",  {31'd0, bus.rd_valid}, 32'd0);
    chk("issue1_re",  {31'd0, bus.ram_re}, 32'd1);
    chk("issue1_adr", {26'd0, bus.ram_addr}, 32'd1);
    tick();
    chk("rd1_lvl_0",  {25'd0, bus.level}, 32'd0);
    tick();
    bus.rd_req = 1'b0;
    chk("data1_vld",  {31'd0, bus.rd_valid}, 32'd1);
    chk("data1_val",  {16'd0, bus.rd_data}, 32'h00001234);
    chk("empty_after",{31'd0, bus.empty}, 32'd1);
    tick();

    // write during RD goes pending, coincides with another write in DATA
    wr_word(16'h1111); wr_word(16'h2222); wr_word(16'h3333);
    void'(q.pop_front());
    bus.rd_req = 1'b1; #1;
    chk("pend_issue_adr", {26'd0, bus.ram_addr}, 32'd2);
    tick();
    bus.rd_req = 1'b0;
    bus.wr_pulse = 1'b1; bus.wr_data = 16'hBEEF; #1;
    chk("rdcyc_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rdcyc_re", {31'd0, bus.ram_re}, 32'd0);
    tick();
    bus.wr_data = 16'hCAFE; #1;
    chk("dcyc_vld",   {31'd0, bus.rd_valid}, 32'd1);
    chk("dcyc_data",  {16'd0, bus.rd_data}, 32'h00001111);
    chk("dcyc_we",    {31'd0, bus.ram_we}, 32'd1);
    chk("dcyc_addr",  {26'd0, bus.ram_addr}, 32'd5);
    chk("dcyc_wdata", {16'd0, bus.ram_wdata}, 32'h0000BEEF);
    chk("dcyc_lvl",   {25'd0, bus.level}, 32'd3);
    tick();
    bus.wr_pulse = 1'b0; #1;
    chk("pend2_we",    {31'd0, bus.ram_we}, 32'd1);
    chk("pend2_addr",  {26'd0, bus.ram_addr}, 32'd6);
    chk("pend2_wdata", {16'd0, bus.ram_wdata}, 32'h0000CAFE);
    chk("pend2_lvl",   {25'd0, bus.level}, 32'd4);
    tick();
    q.push_back(16'hBEEF); q.push_back(16'hCAFE);
    while (q.size() > 0) read_q();
    chk("drain_lvl", {25'd0, bus.level}, 32'd0);

    // clear, fill to full, overflow on the extra write, drain in order
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.wr_pulse = 1'b1;
      bus.wr_data  = 16'h1000 + 16'(i);
      if (i == 0) begin
        #1 chk("fill_first_addr", {26'd0, bus.ram_addr}, 32'd0);
      end
      tick();
      q.push_back(16'h1000 + 16'(i));
    end
    chk("full_flag", {31'd0, bus.full}, 32'd1);
    chk("full_lvl",  {25'd0, bus.level}, N);
    chk("full_ovf0", {31'd0, bus.overflow}, 32'd0);
    bus.wr_data = 16'hFFFF; #1;
    chk("drop_we", {31'd0, bus.ram_we}, 32'd0);
    tick();
    bus.wr_pulse = 1'b0;
    chk("drop_ovf", {31'd0, bus.overflow}, 32'd1);
    chk("drop_lvl", {25'd0, bus.level}, N);
    while (q.size() > 0) read_q();
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);
    chk("drain_full",  {31'd0, bus.full}, 32'd0);
    chk("ovf_sticky",  {31'd0, bus.overflow}, 32'd1);
    bus.wr_pulse = 1'b1; bus.wr_data = 16'hABCD; #1;
    chk("wrap_wr_addr", {26'd0, bus.ram_addr}, 32'd0);
    tick();
    bus.wr_pulse = 1'b0;
    q.push_back(16'hABCD);
    bus.rd_req = 1'b1; #1;
    chk("wrap_rd_addr", {26'd0, bus.ram_addr}, 32'd0);
    read_q();

    // interleave writes and reads across the 63 -> 0 boundary
    for (int i = 0; i < N - 4; i++) begin
      wr_word(16'h2000 + 16'(i));
      read_q();
    end
    for (int i = 0; i < 6; i++) begin
      wr_word(16'h3000 + 16'(2*i));
      wr_word(16'h3001 + 16'(2*i));
      read_q();
    end
    chk("interleave_lvl", {25'd0, bus.level}, 32'd6);
    while (q.size() > 0) read_q();
    chk("interleave_empty", {31'd0, bus.empty}, 32'd1);

    // clear during RD with 5 words stored; clear also beats a wr_pulse
    for (int i = 0; i < 5; i++) wr_word(16'h4000 + 16'(i));
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    bus.clear = 1'b1; bus.wr_pulse = 1'b1; bus.wr_data = 16'hDEAD; #1;
    chk("clr_we", {31'd0, bus.ram_we}, 32'd0);
    tick();
    bus.clear = 1'b0; bus.wr_pulse = 1'b0;
    chk("clr_vld",   {31'd0, bus.rd_valid}, 32'd0);
    chk("clr_lvl",   {25'd0, bus.level}, 32'd0);
    chk("clr_ovf",   {31'd0, bus.overflow}, 32'd0);
    chk("clr_empty", {31'd0, bus.empty}, 32'd1);
    tick();
    chk("clr_vld2",  {31'd0, bus.rd_valid}, 32'd0);
    q.delete();
    bus.wr_pulse = 1'b1; bus.wr_data = 16'h5555; #1;
    chk("clr_next_addr", {26'd0, bus.ram_addr}, 32'd0);
    tick();
    bus.wr_pulse = 1'b0;
    q.push_back(16'h5555);
    read_q();

    // asynchronous reset in the middle of the DATA cycle
    wr_word(16'h7777);
    void'(q.pop_front());
    bus.rd_req = 1'b1; tick();
    bus.rd_req = 1'b0; tick();
    chk("pre_rst_vld",  {31'd0, bus.rd_valid}, 32'd1);
    chk("pre_rst_data", {16'd0, bus.rd_data}, 32'h00007777);
    #2;
    reset = 1'b0; bus.wr_pulse = 1'b1; bus.rd_req = 1'b1; #1;
    chk("arst_vld",   {31'd0, bus.rd_valid}, 32'd0);
    chk("arst_data",  {16'd0, bus.rd_data}, 32'd0);
    chk("arst_lvl",   {25'd0, bus.level}, 32'd0);
    chk("arst_empty", {31'd0, bus.empty}, 32'd1);
    chk("arst_we",    {31'd0, bus.ram_we}, 32'd0);
    chk("arst_re",    {31'd0, bus.ram_re}, 32'd0);
    chk("arst_addr",  {26'd0, bus.ram_addr}, 32'd0);
    bus.wr_pulse = 1'b0; bus.rd_req = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_rst_vld", {31'd0, bus.rd_valid}, 32'd0);
    chk("post_rst_lvl", {25'd0, bus.level}, 32'd0);

    chk("we_re_overlap", overlap, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
